center_collision_scanner: RTL and testbench

//  Sequences collision checks for the two lightbikes. On request, scans the centre window
//  (rows 7..22, cols 8..22) of the 30x30 tile at a player's start address in the trail framebuffer.

---
 rtl/center_collision_scanner_pkg.sv | 35 +++
 rtl/center_collision_scanner_addr_gen.sv | 52 +++++
 rtl/center_collision_scanner.sv | 126 ++++++++++++
 tb/tb_center_collision_scanner.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/center_collision_scanner_pkg.sv
`default_nettype none
//============================================================================
// Module : center_collision_scanner_pkg
// Brief  : Shared tile-window constants and scanner state encodings.
// Rev    : 1.0 - initial release
//============================================================================
package center_collision_scanner_pkg;

  localparam int SCREEN_W  = 640;
  localparam int ADDR_W    = 19;
  localparam int PIX_W     = 3;
  localparam int ROW_MIN   = 7;
  localparam int ROW_MAX   = 22;
  localparam int COL_MIN   = 8;
  localparam int COL_MAX   = 22;
  localparam int BG_COLOR  = 0;
  localparam int TILE_SIZE = 30;
  localparam int IDX_W     = $clog2(TILE_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  // Same window test the renderer uses when drawing the bike body.
  function automatic logic in_center(input logic [IDX_W-1:0] row,
                                     input logic [IDX_W-1:0] col);
    return (row >= IDX_W'(ROW_MIN)) && (row <= IDX_W'(ROW_MAX)) &&
           (col >= IDX_W'(COL_MIN)) && (col <= IDX_W'(COL_MAX));
  endfunction

endpackage
`default_nettype wire

// File: rtl/center_collision_scanner_addr_gen.sv
`default_nettype none
//============================================================================
// Module : center_addr_gen
// Brief  : Loadable row/column walker producing centre-window read addresses.
// Rev    : 1.0 - initial release
//============================================================================
module center_addr_gen
  import center_collision_scanner_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] c_first_ofs = ADDR_W'(ROW_MIN * SCREEN_W + COL_MIN);
  // Jump from the last centre column of one row to the first of the next.
  localparam logic [ADDR_W-1:0] c_row_step  = ADDR_W'(SCREEN_W - (COL_MAX - COL_MIN));

  logic [IDX_W-1:0]  r_row;
  logic [IDX_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (load) begin
      r_row  <= IDX_W'(ROW_MIN);
      r_col  <= IDX_W'(COL_MIN);
      r_addr <= start_addr + c_first_ofs;
    end else if (advance) begin
      if (r_col == IDX_W'(COL_MAX)) begin
        r_col  <= IDX_W'(COL_MIN);
        r_row  <= r_row + IDX_W'(1);
        r_addr <= r_addr + c_row_step;
      end else begin
        r_col  <= r_col + IDX_W'(1);
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  assign addr = r_addr;
  assign last = (r_row == IDX_W'(ROW_MAX)) && (r_col == IDX_W'(COL_MAX));

endmodule
`default_nettype wire

// File: rtl/center_collision_scanner.sv
`default_nettype none
//============================================================================
// Module : center_collision_scanner
// Brief  : Round-robin collision scan of each bike's tile centre window.
// Rev    : 1.0 - initial release
//============================================================================
module center_collision_scanner
  import center_collision_scanner_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] start_addr0,
  input  logic [ADDR_W-1:0] start_addr1,
  input  logic              mem_gnt,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              gnt_id,
  output logic              done,
  output logic              done_id,
  output logic              hit
);

  scan_state_t r_state;
  logic        r_rr_ptr;
  logic        r_chk;
  logic        r_rd_en;
  logic        r_busy;
  logic        r_gnt_id;
  logic        r_done;
  logic        r_done_id;
  logic        r_hit;

  logic              w_accept;
  logic              w_winner;
  logic              w_advance;
  logic              w_last;
  logic              w_sample_hit;
  logic [ADDR_W-1:0] w_start;

  // Single requester wins outright; on contention the pointer picks.
  assign w_winner     = (req == 2'b11) ? r_rr_ptr : req[1];
  assign w_accept     = (r_state == ST_IDLE) && (req != 2'b00);
  assign w_start      = w_winner ? start_addr1 : start_addr0;
  assign w_advance    = (r_state == ST_SCAN) && mem_gnt;
  assign w_sample_hit = r_chk && (mem_rd_data != PIX_W'(BG_COLOR));

  center_addr_gen u_addr_gen (
    .clock      (clock),
    .reset      (reset),
    .load       (w_accept),
    .advance    (w_advance),
    .start_addr (w_start),
    .addr       (mem_addr),
    .last       (w_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= 1'b0;
      r_chk     <= 1'b0;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_gnt_id  <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_hit     <= 1'b0;
    end else begin
      // Data returned next cycle belongs to a read accepted this cycle.
      r_chk  <= w_advance;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state  <= ST_SCAN;
            r_gnt_id <= w_winner;
            r_rr_ptr <= ~w_winner;
            r_rd_en  <= 1'b1;
            r_busy   <= 1'b1;
            r_hit    <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (w_sample_hit) begin
            r_state   <= ST_DONE;
            r_rd_en   <= 1'b0;
            r_done    <= 1'b1;
            r_done_id <= r_gnt_id;
            r_hit     <= 1'b1;
          end else if (w_advance && w_last) begin
            r_state <= ST_DRAIN;
            r_rd_en <= 1'b0;
          end
        end
        ST_DRAIN: begin
          r_state   <= ST_DONE;
          r_done    <= 1'b1;
          r_done_id <= r_gnt_id;
          r_hit     <= w_sample_hit;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_hit   <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_rd_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_en = r_rd_en;
  assign busy      = r_busy;
  assign gnt_id    = r_gnt_id;
  assign done      = r_done;
  assign done_id   = r_done_id;
  assign hit       = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_center_collision_scanner.sv
`default_nettype none
//============================================================================
// Module : tb_center_collision_scanner
// Brief  : Table-driven scoreboard bench for center_collision_scanner.
// Rev    : 1.0 - initial release
//============================================================================
module tb_center_collision_scanner;

  localparam int TB_ADDR_W = 19;
  localparam int TB_SCREEN = 640;
  localparam int TB_ROW0   = 7;
  localparam int TB_COL0   = 8;
  localparam int TB_NCOL   = 15;
  localparam int TB_NREAD  = 240;

  typedef struct {
    logic [TB_ADDR_W-1:0] start;
    logic [1:0]           req;
    int                   pix_addr;
    logic [2:0]           pix_val;
    bit                   toggle;
    logic                 exp_id;
    logic                 exp_hit;
    int                   exp_reads;
    int                   exp_done;
  } vec_t;

  logic                 clock;
  logic                 reset;
  logic [1:0]           req;
  logic [TB_ADDR_W-1:0] start_addr0;
  logic [TB_ADDR_W-1:0] start_addr1;
  logic                 mem_gnt;
  logic [2:0]           mem_rd_data = '0;
  logic                 mem_rd_en;
  logic [TB_ADDR_W-1:0] mem_addr;
  logic                 busy;
  logic                 gnt_id;
  logic                 done;
  logic                 done_id;
  logic                 hit;

  logic [2:0]           fb [int];
  logic [TB_ADDR_W-1:0] exp_q [$];
  vec_t                 vecs [8];
  int                   n_pass;
  int                   n_checks;

  center_collision_scanner dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .start_addr0 (start_addr0),
    .start_addr1 (start_addr1),
    .mem_gnt     (mem_gnt),
    .mem_rd_data (mem_rd_data),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .busy        (busy),
    .gnt_id      (gnt_id),
    .done        (done),
    .done_id     (done_id),
    .hit         (hit)
  );

  always #5 clock = ~clock;

  // Framebuffer model: one-cycle read latency, unwritten pixels are background.
  always @(posedge clock) begin
    if (mem_rd_en && mem_gnt)
      mem_rd_data <= fb.exists(int'(mem_addr)) ? fb[int'(mem_addr)] : 3'd0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_scan(input vec_t v, input string tag);
    logic [TB_ADDR_W-1:0] a;
    int cyc = 0;
    int nrd = 0;
    int done_cyc = -1;
    int bad = 0;
    int quiet = 0;
    logic got_hit = 1'b0;
    logic got_id = 1'b0;
    exp_q.delete();
    for (int i = 0; i < TB_NREAD; i++)
      exp_q.push_back(v.start + TB_ADDR_W'((TB_ROW0 + i / TB_NCOL) * TB_SCREEN + TB_COL0 + i % TB_NCOL));
    if (v.pix_val != 3'd0) fb[v.pix_addr] = v.pix_val;
    @(negedge clock);
    start_addr0 = v.req[0] ? v.start : 19'd99999;
    start_addr1 = v.req[1] ? v.start : 19'd99999;
    req = v.req;
    @(posedge clock);
    while (done_cyc < 0 && cyc < 600) begin
      #1;
      cyc++;
      mem_gnt = (v.toggle && (cyc % 2 == 1)) ? 1'b0 : 1'b1;
      if (cyc == 2) begin
        start_addr0 = 19'd5;
        start_addr1 = 19'd5;
      end
      @(negedge clock);
      if (cyc == 1) check($sformatf("%s.start_busy_gnt", tag), 32'({busy, gnt_id}), 32'({1'b1, v.exp_id}));
      if (mem_rd_en && mem_gnt) begin
        nrd++;
        if (exp_q.size() == 0) bad++;
        else begin
          a = exp_q.pop_front();
          if (a !== mem_addr) bad++;
        end
      end
      if (done) begin
        done_cyc = cyc;
        got_hit  = hit;
        got_id   = done_id;
        req      = 2'b00;
      end
      if (done_cyc < 0) @(posedge clock);
    end
    req = 2'b00;
    check($sformatf("%s.done_cycle", tag), 32'(done_cyc), 32'(v.exp_done));
    check($sformatf("%s.hit", tag), 32'(got_hit), 32'(v.exp_hit));
    check($sformatf("%s.done_id", tag), 32'(got_id), 32'(v.exp_id));
    check($sformatf("%s.reads", tag), 32'(nrd), 32'(v.exp_reads));
    check($sformatf("%s.addr_errors", tag), 32'(bad), 32'd0);
    @(negedge clock);
    check($sformatf("%s.post_done_outs", tag), 32'({busy, hit, done, mem_rd_en}), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      if (mem_rd_en || done) quiet++;
    end
    check($sformatf("%s.post_done_quiet", tag), 32'(quiet), 32'd0);
    mem_gnt = 1'b1;
    if (v.pix_val != 3'd0) fb.delete(v.pix_addr);
  endtask

  task automatic rr_sequence();
    logic [3:0] ids = 4'b0000;
    int nd = 0;
    int bad_pair = 0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    start_addr0 = 19'd0;
    start_addr1 = 19'd640;
    mem_gnt = 1'b1;
    req = 2'b11;
    for (int c = 0; c < 1200 && nd < 4; c++) begin
      @(negedge clock);
      if (done) begin
        ids[nd] = done_id;
        if (done_id !== gnt_id) bad_pair++;
        nd++;
      end
    end
    req = 2'b00;
    check("rr.count", 32'(nd), 32'd4);
    check("rr.order", 32'(ids), 32'(4'b1010));
    check("rr.id_match", 32'(bad_pair), 32'd0);
    repeat (2) @(negedge clock);
  endtask

  task automatic reset_midscan();
    int nrd = 0;
    int noise = 0;
    @(negedge clock);
    start_addr1 = 19'd1280;
    mem_gnt = 1'b1;
    req = 2'b10;
    for (int c = 0; c < 400 && nrd < 100; c++) begin
      @(negedge clock);
      if (mem_rd_en && mem_gnt) nrd++;
    end
    check("abort.reached", 32'(nrd), 32'd100);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    req = 2'b00;
    @(negedge clock);
    check("abort.outs", 32'({mem_rd_en, busy, done, hit, gnt_id, done_id}), 32'd0);
    check("abort.addr", 32'(mem_addr), 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (done || mem_rd_en || busy) noise++;
    end
    check("abort.quiet", 32'(noise), 32'd0);
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    req = 2'b00;
    start_addr0 = '0;
    start_addr1 = '0;
    mem_gnt = 1'b1;
    n_pass = 0;
    n_checks = 0;
    //          start      req    pix_addr val   tog   id    hit   reads done
    vecs[0] = '{19'd0,     2'b01, 0,       3'd0, 1'b0, 1'b0, 1'b0, 240,  242};
    vecs[1] = '{19'd6400,  2'b01, 16015,   3'd3, 1'b0, 1'b0, 1'b1, 129,  130};
    vecs[2] = '{19'd6400,  2'b10, 10255,   3'd5, 1'b0, 1'b1, 1'b0, 240,  242};
    vecs[3] = '{19'd3200,  2'b10, 9623,    3'd2, 1'b0, 1'b1, 1'b0, 240,  242};
    vecs[4] = '{19'd0,     2'b01, 0,       3'd0, 1'b1, 1'b0, 1'b0, 240,  482};
    vecs[5] = '{19'd64100, 2'b10, 78202,   3'd1, 1'b0, 1'b1, 1'b1, 240,  242};
    vecs[6] = '{19'd0,     2'b01, 4488,    3'd4, 1'b0, 1'b0, 1'b1, 2,    3};
    vecs[7] = '{19'd0,     2'b10, 4488,    3'd7, 1'b1, 1'b1, 1'b1, 1,    4};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset.outs", 32'({mem_rd_en, busy, done, hit, gnt_id, done_id}), 32'd0);
    check("reset.addr", 32'(mem_addr), 32'd0);

    for (int i = 0; i < 8; i++) run_scan(vecs[i], $sformatf("vec%0d", i));
    rr_sequence();
    reset_midscan();
    run_scan(vecs[0], "restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
